// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: input instruction channel and output immediate channel of imm_gen_pipe.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [2:0]       fmt_out;
    logic             illegal_out;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, instruction, in_tag, out_ready,
        input  in_ready, out_valid, imm_out, fmt_out, illegal_out, out_tag
    );
    modport slave (
        input  in_valid, instruction, in_tag, out_ready,
        output in_ready, out_valid, imm_out, fmt_out, illegal_out, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder followed by a STAGES-deep valid/ready register pipeline.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic           clk,
    input  logic           reset,
    imm_gen_pipe_if.slave  bus
);
    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_ILL = 3'd7;
    localparam bit RV64 = (XLEN == 64);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } stage_t;
    logic [31:0]       w_ins;
    logic [6:0]        w_op;
    logic              w_sh_f3;
    logic [2:0]        w_fmt;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_sh;
    logic              w_acc;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_src_v;
    stage_t            w_src [STAGES];
    logic [STAGES-1:0] r_v;
    stage_t            r_d [STAGES];
    assign w_ins   = bus.instruction;
    assign w_op    = w_ins[6:0];
    assign w_sh_f3 = (w_ins[14:12] == 3'b001) || (w_ins[14:12] == 3'b101);
    // OP-IMM-32 (op[3]=1) always takes a 5-bit shamt, even on RV64
    assign w_sh    = (RV64 && !w_op[3]) ? XLEN'(w_ins[25:20]) : XLEN'(w_ins[24:20]);
    always_comb begin
        w_fmt = F_ILL;
        case (w_op)
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: w_fmt = F_I;
            7'b0010011: w_fmt = w_sh_f3 ? F_SH : F_I;
            7'b0011011: w_fmt = !RV64 ? F_ILL : w_sh_f3 ? F_SH : F_I;
            7'b0100011: w_fmt = F_S;
            7'b1100011: w_fmt = F_B;
            7'b0110111, 7'b0010111: w_fmt = F_U;
            7'b1101111: w_fmt = F_J;
            7'b0110011: w_fmt = F_NONE;
            7'b0111011: w_fmt = RV64 ? F_NONE : F_ILL;
            default: w_fmt = F_ILL;
        endcase
    end
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            F_I:  w_imm = XLEN'($signed(w_ins[31:20]));
            F_S:  w_imm = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
            F_B:  w_imm = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
            F_U:  w_imm = XLEN'($signed({w_ins[31:12], 12'b0}));
            F_J:  w_imm = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
            F_SH: w_imm = w_sh;
            default: w_imm = '0;
        endcase
    end
    // a stage may load if any stage at or after it is empty, or the output drains
    always_comb begin
        logic c;
        c = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            c = c | ~r_v[k];
            w_load[k] = c;
        end
    end
    assign bus.in_ready = w_load[0] & ~reset;
    assign w_acc        = bus.in_valid & bus.in_ready;
    for (genvar s = 0; s < STAGES; s++) begin : g_src
        if (s == 0) begin : g_head
            assign w_src_v[s] = w_acc;
            assign w_src[s]   = {w_imm, w_fmt, bus.in_tag};
        end else begin : g_body
            assign w_src_v[s] = r_v[s-1];
            assign w_src[s]   = r_d[s-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) r_d[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_src_v[k];
                    r_d[k] <= w_src[k];
                end
            end
        end
    end
    assign bus.out_valid   = r_v[STAGES-1];
    assign bus.imm_out     = r_d[STAGES-1].imm;
    assign bus.fmt_out     = r_d[STAGES-1].fmt;
    assign bus.illegal_out = (r_d[STAGES-1].fmt == F_ILL);
    assign bus.out_tag     = r_d[STAGES-1].tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of decode, latency, backpressure and reset on three configurations.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) b32 ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) b2 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) b64 ();
    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(4)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(4)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
    imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(4)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));
    localparam logic [31:0] V32_INS [12] = '{32'hFFF00093, 32'h01F09093, 32'hFE000EE3, 32'h123450B7,
        32'h008000EF, 32'h00000000, 32'h0000001B, 32'hFE112C23, 32'h003100B3, 32'h00008067,
        32'h00000001, 32'h0000003B};
    localparam logic [31:0] V32_IMM [12] = '{32'hFFFFFFFF, 32'h0000001F, 32'hFFFFFFFC, 32'h12345000,
        32'h00000008, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h0, 32'h0};
    localparam logic [2:0] V32_FMT [12] = '{3'd1, 3'd6, 3'd3, 3'd4, 3'd5, 3'd7, 3'd7, 3'd2, 3'd0, 3'd1, 3'd7, 3'd7};
    localparam logic V32_ILL [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] V64_INS [7] = '{32'h800000B7, 32'h03F09093, 32'h0000001B, 32'h0000003B,
        32'hFFF00093, 32'h03F0909B, 32'hFE000EE3};
    localparam logic [63:0] V64_IMM [7] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h0, 64'h0,
        64'hFFFFFFFFFFFFFFFF, 64'h1F, 64'hFFFFFFFFFFFFFFFC};
    localparam logic [2:0] V64_FMT [7] = '{3'd4, 3'd6, 3'd1, 3'd0, 3'd1, 3'd6, 3'd3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_chk++;
        if ({b32.out_valid, b32.in_ready, b32.imm_out, b32.fmt_out, b32.illegal_out, b32.out_tag} !== '0)
            $display("FAIL reset32 got v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d want all zero",
                b32.out_valid, b32.in_ready, b32.imm_out, b32.fmt_out, b32.illegal_out, b32.out_tag);
        else n_pass++;
        n_chk++;
        if ({b2.out_valid, b2.in_ready, b2.imm_out, b2.fmt_out, b2.illegal_out, b2.out_tag} !== '0)
            $display("FAIL reset_s2 got v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d want all zero",
                b2.out_valid, b2.in_ready, b2.imm_out, b2.fmt_out, b2.illegal_out, b2.out_tag);
        else n_pass++;
        n_chk++;
        if ({b64.out_valid, b64.in_ready, b64.imm_out, b64.fmt_out, b64.illegal_out, b64.out_tag} !== '0)
            $display("FAIL reset64 got v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d want all zero",
                b64.out_valid, b64.in_ready, b64.imm_out, b64.fmt_out, b64.illegal_out, b64.out_tag);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({b32.in_ready, b2.in_ready, b64.in_ready} !== 3'b111)
            $display("FAIL ready_after_reset got %b%b%b want 111", b32.in_ready, b2.in_ready, b64.in_ready);
        else n_pass++;
    endtask

    task automatic test_decode32();
        for (int i = 0; i < 12; i++) begin
            b32.in_valid = 1'b1;
            b32.instruction = V32_INS[i];
            b32.in_tag = 4'(i);
            tick();
            n_chk++;
            if ({b32.out_valid, b32.imm_out, b32.fmt_out, b32.illegal_out, b32.out_tag}
                    !== {1'b1, V32_IMM[i], V32_FMT[i], V32_ILL[i], 4'(i)})
                $display("FAIL decode32[%0d] ins=%h got v=%b imm=%h fmt=%0d ill=%b tag=%0d want v=1 imm=%h fmt=%0d ill=%b tag=%0d",
                    i, V32_INS[i], b32.out_valid, b32.imm_out, b32.fmt_out, b32.illegal_out, b32.out_tag,
                    V32_IMM[i], V32_FMT[i], V32_ILL[i], i);
            else n_pass++;
        end
        b32.in_valid = 1'b0;
        tick();
        n_chk++;
        if (b32.out_valid !== 1'b0) $display("FAIL decode32_drain got v=%b want 0", b32.out_valid);
        else n_pass++;
    endtask

    task automatic test_decode64();
        for (int i = 0; i < 7; i++) begin
            b64.in_valid = 1'b1;
            b64.instruction = V64_INS[i];
            b64.in_tag = 4'(i + 3);
            tick();
            n_chk++;
            if ({b64.out_valid, b64.imm_out, b64.fmt_out, b64.illegal_out, b64.out_tag}
                    !== {1'b1, V64_IMM[i], V64_FMT[i], 1'b0, 4'(i + 3)})
                $display("FAIL decode64[%0d] ins=%h got v=%b imm=%h fmt=%0d ill=%b tag=%0d want v=1 imm=%h fmt=%0d ill=0 tag=%0d",
                    i, V64_INS[i], b64.out_valid, b64.imm_out, b64.fmt_out, b64.illegal_out, b64.out_tag,
                    V64_IMM[i], V64_FMT[i], i + 3);
            else n_pass++;
        end
        b64.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        b2.out_ready = 1'b1;
        b2.in_valid = 1'b1;
        b2.instruction = 32'hFFF00093;
        b2.in_tag = 4'd5;
        tick();
        n_chk++;
        if (b2.out_valid !== 1'b0) $display("FAIL latency_s2_early got v=%b want 0", b2.out_valid);
        else n_pass++;
        b2.instruction = 32'h123450B7;
        b2.in_tag = 4'd6;
        tick();
        n_chk++;
        if ({b2.out_valid, b2.out_tag, b2.imm_out} !== {1'b1, 4'd5, 32'hFFFFFFFF})
            $display("FAIL b2b_first got v=%b tag=%0d imm=%h want v=1 tag=5 imm=ffffffff",
                b2.out_valid, b2.out_tag, b2.imm_out);
        else n_pass++;
        b2.instruction = 32'h008000EF;
        b2.in_tag = 4'd7;
        tick();
        n_chk++;
        if ({b2.out_valid, b2.out_tag, b2.imm_out} !== {1'b1, 4'd6, 32'h12345000})
            $display("FAIL b2b_second got v=%b tag=%0d imm=%h want v=1 tag=6 imm=12345000",
                b2.out_valid, b2.out_tag, b2.imm_out);
        else n_pass++;
        b2.in_valid = 1'b0;
        tick();
        n_chk++;
        if ({b2.out_valid, b2.out_tag, b2.imm_out} !== {1'b1, 4'd7, 32'h00000008})
            $display("FAIL b2b_third got v=%b tag=%0d imm=%h want v=1 tag=7 imm=00000008",
                b2.out_valid, b2.out_tag, b2.imm_out);
        else n_pass++;
        tick();
        n_chk++;
        if (b2.out_valid !== 1'b0) $display("FAIL b2b_drain got v=%b want 0", b2.out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        b2.out_ready = 1'b0;
        b2.in_valid = 1'b1;
        b2.instruction = 32'hFFF00093;
        b2.in_tag = 4'd1;
        tick();
        b2.instruction = 32'h123450B7;
        b2.in_tag = 4'd2;
        n_chk++;
        if (b2.in_ready !== 1'b1) $display("FAIL bp_ready_second got rdy=%b want 1", b2.in_ready);
        else n_pass++;
        tick();
        b2.instruction = 32'h008000EF;
        b2.in_tag = 4'd3;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({b2.in_ready, b2.out_valid, b2.out_tag, b2.imm_out, b2.fmt_out} !== {1'b0, 1'b1, 4'd1, 32'hFFFFFFFF, 3'd1})
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b tag=%0d imm=%h fmt=%0d want rdy=0 v=1 tag=1 imm=ffffffff fmt=1",
                    i, b2.in_ready, b2.out_valid, b2.out_tag, b2.imm_out, b2.fmt_out);
            else n_pass++;
            tick();
        end
        b2.out_ready = 1'b1;
        #1;
        n_chk++;
        if ({b2.in_ready, b2.out_tag} !== {1'b1, 4'd1})
            $display("FAIL bp_release got rdy=%b tag=%0d want rdy=1 tag=1", b2.in_ready, b2.out_tag);
        else n_pass++;
        tick();
        b2.in_valid = 1'b0;
        n_chk++;
        if ({b2.out_valid, b2.out_tag, b2.imm_out} !== {1'b1, 4'd2, 32'h12345000})
            $display("FAIL bp_out2 got v=%b tag=%0d imm=%h want v=1 tag=2 imm=12345000", b2.out_valid, b2.out_tag, b2.imm_out);
        else n_pass++;
        tick();
        n_chk++;
        if ({b2.out_valid, b2.out_tag, b2.imm_out} !== {1'b1, 4'd3, 32'h00000008})
            $display("FAIL bp_out3 got v=%b tag=%0d imm=%h want v=1 tag=3 imm=00000008", b2.out_valid, b2.out_tag, b2.imm_out);
        else n_pass++;
        tick();
        n_chk++;
        if (b2.out_valid !== 1'b0) $display("FAIL bp_drain got v=%b want 0", b2.out_valid);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        b2.out_ready = 1'b0;
        b2.in_valid = 1'b1;
        b2.instruction = 32'hFE000EE3;
        b2.in_tag = 4'd9;
        tick();
        b2.in_tag = 4'd10;
        tick();
        b2.in_valid = 1'b0;
        n_chk++;
        if ({b2.out_valid, b2.out_tag} !== {1'b1, 4'd9})
            $display("FAIL mid_inflight got v=%b tag=%0d want v=1 tag=9", b2.out_valid, b2.out_tag);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_chk++;
        if ({b2.out_valid, b2.in_ready, b2.imm_out, b2.fmt_out, b2.illegal_out, b2.out_tag} !== '0)
            $display("FAIL mid_reset got v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d want all zero",
                b2.out_valid, b2.in_ready, b2.imm_out, b2.fmt_out, b2.illegal_out, b2.out_tag);
        else n_pass++;
        reset = 1'b0;
        b2.out_ready = 1'b1;
        #1;
        n_chk++;
        if (b2.in_ready !== 1'b1) $display("FAIL mid_ready got rdy=%b want 1", b2.in_ready);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (b2.out_valid !== 1'b0) $display("FAIL mid_ghost[%0d] got v=%b tag=%0d want v=0", i, b2.out_valid, b2.out_tag);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        b32.in_valid = 1'b0; b32.instruction = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b2.in_valid = 1'b0;  b2.instruction = '0;  b2.in_tag = '0;  b2.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.instruction = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
        test_reset();
        test_decode32();
        test_decode64();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate width; legal values 32 or 64.
REQ-002 Parameter STAGES, default 1, register stages from input to output; legal range 1..4.
REQ-003 Parameter TAG_W, default 4, width of the sideband tag.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  instruction present on instruction/in_tag.
REQ-007 in_ready  output  1  block accepts the input this cycle.
REQ-008 instruction  input  32  raw RISC-V instruction word.
REQ-009 in_tag  input  TAG_W  opaque sideband, carried unchanged.
REQ-010 out_valid  output  1  result present on the output bus.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 imm_out  output  XLEN  decoded immediate.
REQ-013 fmt_out  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ILLEGAL.
REQ-014 illegal_out  output  1  unsupported encoding.
REQ-015 out_tag  output  TAG_W  in_tag of the same transaction.

Function
REQ-016 Transfer occurs on a port only when valid and ready are both high in the same cycle; results leave in acceptance order.
REQ-017 Decode is combinational on the accepted instruction; the result registers in stage 0 and shifts through STAGES valid-qualified registers.
REQ-018 A stage loads when it is empty or when its contents move on in the same cycle; otherwise it holds.
REQ-019 in_ready = stage 0 empty OR stage 0 advancing; no combinational path from in_valid to in_ready.
REQ-020 With out_ready held high: latency is STAGES cycles from input acceptance to out_valid, and throughput is one result per cycle.
REQ-021 With out_ready low: the pipeline holds exactly STAGES transactions and then deasserts in_ready; output fields stay stable while out_valid=1 and out_ready=0.
REQ-022 instruction[1:0] != 2'b11 -> ILLEGAL.
REQ-023 Opcodes 0000011 (LOAD), 1100111 (JALR), 0001111 (MISC-MEM), 1110011 (SYSTEM) -> I: sign-extend instruction[31:20].
REQ-024 Opcode 0010011 (OP-IMM): funct3 001/101 -> SHAMT, zero-extend instruction[24:20] (XLEN=32) or instruction[25:20] (XLEN=64); all other funct3 -> I.
REQ-025 Opcode 0100011 -> S: sign-extend {instruction[31:25], instruction[11:7]}.
REQ-026 Opcode 1100011 -> B: sign-extend {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
REQ-027 Opcodes 0110111 (LUI), 0010111 (AUIPC) -> U: {instruction[31:12], 12'b0}, sign-extended to XLEN.
REQ-028 Opcode 1101111 -> J: sign-extend {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
REQ-029 Opcode 0110011 (OP) -> NONE, imm_out=0.
REQ-030 XLEN=64 only: 0011011 (OP-IMM-32) decodes as OP-IMM with a 5-bit shamt; 0111011 (OP-32) -> NONE. With XLEN=32 both opcodes are ILLEGAL.
REQ-031 Any other opcode -> ILLEGAL, imm_out=0, illegal_out=1; illegal_out=0 for every other format.
REQ-032 Illegal encodings flow through the pipeline like any transaction and are never dropped.

Reset
REQ-033 While reset=1 all stage valids clear, out_valid=0, and imm_out, fmt_out, illegal_out, out_tag=0.
REQ-034 in_ready=0 while reset=1; in_ready=1 on the first cycle after reset deasserts.
REQ-035 Reset mid-operation discards all in-flight transactions; nothing accepted before reset appears afterwards.

Verification
REQ-036 STAGES=1, out_ready=1: 0xFFF00093 -> one cycle later imm_out=0xFFFFFFFF, fmt=I; 0x01F09093 -> imm_out=0x0000001F, fmt=SHAMT.
REQ-037 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt=B; 0x123450B7 -> 0x12345000, fmt=U; 0x008000EF -> 0x00000008, fmt=J.
REQ-038 0x00000000 -> illegal_out=1, fmt=ILLEGAL, imm_out=0; 0x0000001B with XLEN=32 -> ILLEGAL; same word with XLEN=64 -> fmt=I, illegal_out=0.
REQ-039 STAGES=2, out_ready=0, back-to-back pushes with tags 1,2,3 -> only tags 1 and 2 accepted, in_ready=0; raise out_ready -> tags 1,2,3 emerge in order on consecutive cycles.
REQ-040 XLEN=64: 0x800000B7 -> imm_out=0xFFFFFFFF80000000; 0x03F09093 -> 0x000000000000003F, fmt=SHAMT.
REQ-041 Reset asserted with 2 transactions in flight -> out_valid=0 next cycle, and none of them is delivered after reset deasserts.
